// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port YX router: flit/address widths, port names
// and the packed header destination layout.
package noc_pkg;

  localparam int FLIT_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int PKT_FLITS = 4;

  typedef enum logic [2:0] {
    N = 3'd0,
    S = 3'd1,
    W = 3'd2,
    E = 3'd3,
    L = 3'd4
  } dir_e;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } hdr_addr_t;

  // Packet position classes of the flit currently at the buffer head.
  typedef enum logic {
    HEADER = 1'b0,
    BODY   = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/input_buffer_if.sv
// Link-side handshake and arbiter-side status bundle of one router input buffer.
// The upstream/arbiter side takes the master modport, the buffer the slave one.
interface input_buffer_if
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int DEPTH      = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ib_data_i;
  logic                  ib_valid_i;
  logic                  ib_ready_o;
  logic                  ib_read_i;
  logic [DATA_WIDTH-1:0] ib_data_o;
  logic                  ib_empty_o;
  logic                  ib_full_o;
  logic [CNT_W-1:0]      ib_count_o;
  logic                  ib_header_o;
  logic [ADDR_W-1:0]     ib_addr_header_o;

  modport master (
    output ib_data_i,
    output ib_valid_i,
    output ib_read_i,
    input  ib_ready_o,
    input  ib_data_o,
    input  ib_empty_o,
    input  ib_full_o,
    input  ib_count_o,
    input  ib_header_o,
    input  ib_addr_header_o
  );

  modport slave (
    input  ib_data_i,
    input  ib_valid_i,
    input  ib_read_i,
    output ib_ready_o,
    output ib_data_o,
    output ib_empty_o,
    output ib_full_o,
    output ib_count_o,
    output ib_header_o,
    output ib_addr_header_o
  );

endinterface

// File: rtl/ib_fifo_core.sv
// First-word-fall-through FIFO storage: array, pointers and occupancy count.
// The head word is read combinationally so it is visible one cycle after its write.
module ib_fifo_core
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  rd_fire_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_fire;
  logic                  rd_fire;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  // No bypass in either direction: a full FIFO refuses writes even when read.
  assign wr_fire   = wr_valid_i && !full_o;
  assign rd_fire   = rd_en_i && !empty_o;
  assign rd_fire_o = rd_fire;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/input_buffer.sv
// Router input port buffer: FIFO plus a packet-position tracker that keeps the
// header destination stable on ib_addr_header_o while body flits drain.
module input_buffer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_W,
  parameter int DEPTH      = 4,
  parameter int PKT_FLITS  = noc_pkg::PKT_FLITS
) (
  input logic           clk,
  input logic           reset,
  input_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int POS_W = $clog2(PKT_FLITS);

  logic [DATA_WIDTH-1:0] head_data;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  rd_fire;

  logic [POS_W-1:0]      flit_pos_q, flit_pos_d;
  hdr_addr_t             hdr_addr_q, hdr_addr_d;
  pkt_state_e            state;

  ib_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_data_i  (bus.ib_data_i),
    .wr_valid_i (bus.ib_valid_i),
    .rd_en_i    (bus.ib_read_i),
    .rd_data_o  (head_data),
    .empty_o    (empty),
    .full_o     (full),
    .count_o    (count),
    .rd_fire_o  (rd_fire)
  );

  // Tracker state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_pos_q <= '0;
      hdr_addr_q <= '0;
    end else begin
      flit_pos_q <= flit_pos_d;
      hdr_addr_q <= hdr_addr_d;
    end
  end

  // Next-state: advance one position per accepted read, capture the header address.
  always_comb begin
    flit_pos_d = flit_pos_q;
    hdr_addr_d = hdr_addr_q;
    if (rd_fire) begin
      if (flit_pos_q == POS_W'(PKT_FLITS - 1)) begin
        flit_pos_d = '0;
      end else begin
        flit_pos_d = flit_pos_q + POS_W'(1);
      end
      if (flit_pos_q == '0) begin
        hdr_addr_d = hdr_addr_t'(head_data[ADDR_W-1:0]);
      end
    end
  end

  // Outputs: live header address at a header flit, held address otherwise,
  // which also covers empty gaps in the middle of a packet.
  always_comb begin
    state                = (flit_pos_q == '0) ? HEADER : BODY;
    bus.ib_header_o      = (state == HEADER) && !empty;
    bus.ib_addr_header_o = hdr_addr_q;
    if (state == HEADER && !empty) begin
      bus.ib_addr_header_o = head_data[ADDR_W-1:0];
    end
  end

  assign bus.ib_data_o  = head_data;
  assign bus.ib_empty_o = empty;
  assign bus.ib_full_o  = full;
  assign bus.ib_ready_o = !full;
  assign bus.ib_count_o = count;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: reset, overflow, header hold across gaps,
// full/empty corner cases and a wrapping 3-packet stream.
module tb_input_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PKT   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  input_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  input_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .PKT_FLITS  (PKT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".empty"},  32'(bus.ib_empty_o),       32'd1);
    check({tag, ".full"},   32'(bus.ib_full_o),        32'd0);
    check({tag, ".ready"},  32'(bus.ib_ready_o),       32'd1);
    check({tag, ".count"},  32'(bus.ib_count_o),       32'd0);
    check({tag, ".data"},   bus.ib_data_o,             32'd0);
    check({tag, ".header"}, 32'(bus.ib_header_o),      32'd0);
    check({tag, ".addr"},   32'(bus.ib_addr_header_o), 32'h00);
  endtask

  logic [31:0] flits [12];
  logic [31:0] fill_seq [4];

  initial begin
    bus.ib_data_i  = '0;
    bus.ib_valid_i = 1'b0;
    bus.ib_read_i  = 1'b0;

    // Power-on reset
    tick();
    tick();
    check_reset_outputs("por");
    reset = 1'b1;
    tick();

    // Reset mid-operation, asserted between clock edges
    bus.ib_valid_i = 1'b1;
    bus.ib_data_i = 32'h0000_0011; tick();
    bus.ib_data_i = 32'h0000_0022; tick();
    bus.ib_data_i = 32'h0000_0033; tick();
    bus.ib_valid_i = 1'b0;
    check("mid.count",  32'(bus.ib_count_o),       32'd3);
    check("mid.data",   bus.ib_data_o,             32'h11);
    check("mid.header", 32'(bus.ib_header_o),      32'd1);
    check("mid.addr",   32'(bus.ib_addr_header_o), 32'h11);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs("arst");
    tick();
    reset = 1'b1;
    tick();

    // Fill and overflow
    fill_seq[0] = 32'hA1; fill_seq[1] = 32'hA2; fill_seq[2] = 32'hA3; fill_seq[3] = 32'hA4;
    bus.ib_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ib_data_i = fill_seq[i];
      tick();
    end
    check("fill.full",  32'(bus.ib_full_o),  32'd1);
    check("fill.ready", 32'(bus.ib_ready_o), 32'd0);
    check("fill.count", 32'(bus.ib_count_o), 32'd4);
    bus.ib_data_i = 32'hA5;
    tick();
    check("ovf.count", 32'(bus.ib_count_o), 32'd4);
    check("ovf.head",  bus.ib_data_o,       32'hA1);

    // Full with simultaneous read and write: read wins, write refused
    bus.ib_read_i = 1'b1;
    tick();
    bus.ib_read_i  = 1'b0;
    bus.ib_valid_i = 1'b0;
    check("fullrw.count", 32'(bus.ib_count_o), 32'd3);
    check("fullrw.ready", 32'(bus.ib_ready_o), 32'd1);
    check("fullrw.full",  32'(bus.ib_full_o),  32'd0);
    check("fullrw.head",  bus.ib_data_o,       32'hA2);
    for (int i = 1; i < 4; i++) begin
      check("drain.head", bus.ib_data_o, fill_seq[i]);
      bus.ib_read_i = 1'b1;
      tick();
      bus.ib_read_i = 1'b0;
    end
    check("drain.empty", 32'(bus.ib_empty_o), 32'd1);
    check("drain.count", 32'(bus.ib_count_o), 32'd0);

    // Header hold across body flits and an empty gap
    bus.ib_valid_i = 1'b1;
    bus.ib_data_i = 32'hDEAD_0023; tick();
    bus.ib_data_i = 32'h0000_00AA; tick();
    bus.ib_data_i = 32'h0000_00BB; tick();
    bus.ib_valid_i = 1'b0;
    check("hh.hdr_flag", 32'(bus.ib_header_o),      32'd1);
    check("hh.hdr_addr", 32'(bus.ib_addr_header_o), 32'h23);
    bus.ib_read_i = 1'b1;
    tick();
    check("hh.b1.data", bus.ib_data_o,             32'hAA);
    check("hh.b1.flag", 32'(bus.ib_header_o),      32'd0);
    check("hh.b1.addr", 32'(bus.ib_addr_header_o), 32'h23);
    tick();
    check("hh.b2.data", bus.ib_data_o,             32'hBB);
    check("hh.b2.addr", 32'(bus.ib_addr_header_o), 32'h23);
    tick();
    bus.ib_read_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hh.gap.empty", 32'(bus.ib_empty_o),       32'd1);
      check("hh.gap.addr",  32'(bus.ib_addr_header_o), 32'h23);
      check("hh.gap.flag",  32'(bus.ib_header_o),      32'd0);
      tick();
    end
    bus.ib_valid_i = 1'b1;
    bus.ib_data_i  = 32'h0000_00CC;
    tick();
    bus.ib_valid_i = 1'b0;
    check("hh.b3.data", bus.ib_data_o,             32'hCC);
    check("hh.b3.flag", 32'(bus.ib_header_o),      32'd0);
    check("hh.b3.addr", 32'(bus.ib_addr_header_o), 32'h23);
    bus.ib_read_i = 1'b1;
    tick();
    bus.ib_read_i = 1'b0;
    check("hh.end.empty", 32'(bus.ib_empty_o),       32'd1);
    check("hh.end.addr",  32'(bus.ib_addr_header_o), 32'h23);

    // Empty with simultaneous read and write: read ignored, tracker unchanged
    bus.ib_read_i  = 1'b1;
    bus.ib_valid_i = 1'b1;
    bus.ib_data_i  = 32'h0000_0005;
    tick();
    bus.ib_read_i  = 1'b0;
    bus.ib_valid_i = 1'b0;
    check("emptyrw.data",  bus.ib_data_o,             32'h5);
    check("emptyrw.count", 32'(bus.ib_count_o),       32'd1);
    check("emptyrw.flag",  32'(bus.ib_header_o),      32'd1);
    check("emptyrw.addr",  32'(bus.ib_addr_header_o), 32'h05);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("emptyrw.rst.count", 32'(bus.ib_count_o), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Three back-to-back packets, one write and one read per cycle
    for (int k = 0; k < 12; k++) begin
      flits[k] = 32'hC0DE_0010 + 32'(k) * 32'h0000_0111;
    end
    bus.ib_valid_i = 1'b1;
    bus.ib_data_i  = flits[0];
    tick();
    for (int k = 0; k < 12; k++) begin
      check("strm.data",  bus.ib_data_o,             flits[k]);
      check("strm.flag",  32'(bus.ib_header_o),      32'((k % PKT) == 0));
      check("strm.addr",  32'(bus.ib_addr_header_o), {24'h0, flits[(k / PKT) * PKT][7:0]});
      check("strm.count", 32'(bus.ib_count_o),       32'd1);
      bus.ib_read_i  = 1'b1;
      bus.ib_valid_i = (k < 11);
      bus.ib_data_i  = (k < 11) ? flits[k + 1] : 32'h0;
      tick();
    end
    bus.ib_read_i  = 1'b0;
    bus.ib_valid_i = 1'b0;
    check("strm.end.empty", 32'(bus.ib_empty_o),       32'd1);
    check("strm.end.addr",  32'(bus.ib_addr_header_o), {24'h0, flits[8][7:0]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
